seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the board's single 4-digit seven-segment display between three requesters: game score, ALU result and PC/debug value. It arbitrates round-robin and guarantees each winner a minimum on-screen tenure. It drives the registered 16-bit value into the seven_seg digit multiplexer. It sits between the datapath/game logic and the display driver, in the same 10 MHz clock domain.

Parameters:
HOLD_CYCLES, 10000000, minimum grant tenure in clk cycles (1 s at 10 MHz); a value of 0 is treated as 1.
CNT_W, 24, width of the tenure counter; must hold HOLD_CYCLES-1.
IDLE_DATA, 16'h0000, value shown after reset until the first grant.

Ports:
clk  input  1  system clock, 10 MHz
reset  input  1  synchronous, active-low reset; sampled on posedge clk
req  input  3  request per source; bit 0 = score, bit 1 = ALU, bit 2 = PC
src0_data  input  16  source 0 display value
src1_data  input  16  source 1 display value
src2_data  input  16  source 2 display value
grant  output  3  one-hot grant, registered; 3'b000 when idle
active_src  output  2  index of the current/last winner; 2'd0 after reset
busy  output  1  high while any grant is asserted
disp_data  output  16  registered value to the seven_seg data input

Behaviour:
- Reset (reset==0 at posedge clk): grant=0, busy=0, active_src=0, disp_data=IDLE_DATA, counter=0, state=IDLE. The round-robin pointer is set so source 0 has first priority. Reset mid-tenure aborts the tenure immediately.
- States: IDLE and SHOW.
- IDLE:
  - grant=0; disp_data holds its last value.
  - If req!=0 at edge n, the winner is chosen round-robin, searching upward from (last winner+1) mod 3.
  - At edge n (registered): grant one-hot for the winner, active_src=winner, busy=1, counter=HOLD_CYCLES-1, disp_data=winner's src data; go to SHOW.
- SHOW, per edge:
  - If req[active_src]==1, then disp_data <= src{active_src}_data. The display value tracks its source with 1-cycle latency.
  - If req[active_src]==0, disp_data freezes.
  - If counter!=0, decrement it.
- Tenure end (counter==0 in SHOW):
  - Other req pending: switch directly to the next round-robin winner on that edge. Grant moves one-hot to one-hot with no idle cycle; counter is reloaded and disp_data is loaded from the new source.
  - No other req and own req high: keep the grant and keep counter at 0. Re-arbitrate every cycle thereafter.
  - No req at all: go to IDLE; grant=0, busy=0, disp_data and active_src hold.
- Grant is therefore high for at least HOLD_CYCLES consecutive cycles, even if the requester drops req early.
- A requester cannot be served twice in a row while another request is pending.
- Simultaneous requests: resolved by the round-robin pointer only. Requests are not queued or latched; req must be held until grant.
- grant is never multi-hot; it never changes except at reset, IDLE→SHOW, tenure end, or preemption (optional feature).

Optional Feature:
Macro SEG_ARB_PREEMPT_EN.
- Defined:
  - req[0] (score) preempts. If req[0]==1 while SHOW holds source 1 or 2, the next edge grants source 0 regardless of counter: counter reloads and disp_data is loaded from src0_data.
  - The round-robin pointer is then updated as if source 0 had won normally.
  - Source 0 cannot preempt itself.
- Not defined: pure round-robin; no preemption logic is synthesized.

Test Plan:
All scenarios use HOLD_CYCLES=4.
- Reset and idle: hold reset=0 for 3 cycles, req=0 → grant=000, busy=0, disp_data=16'h0000. Release reset with req still 0 → outputs unchanged.
- Single request: req=001, src0_data=16'h1234 at edge n → grant=001 and disp_data=1234 at n. Change src0 to 16'h5678 → disp_data=5678 one cycle later. Drop req at n+1 → grant stays high through n+3, IDLE at n+4, disp_data frozen.
- Round-robin: req=111 held constant → grants 001,010,100,001, each exactly 4 cycles, switching with no zero-grant cycle. active_src follows 0,1,2,0.
- Early release and sole holder: grant src1, drop req[1] after 1 cycle with req=000 → grant=010 held 4 cycles, then 000. Separately, hold req[1] alone for 10 cycles → grant stays 010. Raise req[2] → grant moves to 100 on the next edge.
- Mid-tenure reset: reset=0 during counter=2 of source 2 → next edge grant=000, disp_data=IDLE_DATA, active_src=0.
- SEG_ARB_PREEMPT_EN: with source 2 granted and counter=3, raise req[0] → grant=001 on the next edge, tenure reloaded to 4 cycles. With the macro undefined, the same stimulus leaves source 2 granted until expiry.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display among three sources.
// Optional score preemption is enabled by defining SEG_ARB_PREEMPT_EN.
module seg_display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 10000000,
   parameter int unsigned CNT_W       = 24,
   parameter logic [15:0] IDLE_DATA   = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [15:0] src0_data,
   input  logic [15:0] src1_data,
   input  logic [15:0] src2_data,
   output logic [2:0]  grant,
   output logic [1:0]  active_src,
   output logic        busy,
   output logic [15:0] disp_data
);

   typedef enum logic {IDLE, SHOW} state_e;

   localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_EFF - 1);

   state_e           state_q, state_d;
   logic [2:0]       grant_q, grant_d;
   logic [1:0]       active_q, active_d;
   logic [1:0]       prio_q, prio_d;
   logic [15:0]      disp_q, disp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             do_load;
   logic [1:0]       load_idx;
   logic [1:0]       win;

   // First requester found searching upward (mod 3) from start.
   function automatic logic [1:0] rr_pick(input logic [2:0] r,
                                          input logic [1:0] start);
      logic [1:0] idx;
      rr_pick = start;
      for (int k = 2; k >= 0; k--) begin
         idx = 2'((int'(start) + k) % 3);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [15:0] src_mux(input logic [1:0] idx,
                                           input logic [15:0] d0,
                                           input logic [15:0] d1,
                                           input logic [15:0] d2);
      unique case (idx)
         2'd1:    src_mux = d1;
         2'd2:    src_mux = d2;
         default: src_mux = d0;
      endcase
   endfunction

   assign win = rr_pick(req, prio_q);

   // State and datapath registers; reset aborts any tenure at once.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= 3'b000;
         active_q <= 2'd0;
         prio_q   <= 2'd0;
         disp_q   <= IDLE_DATA;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         active_q <= active_d;
         prio_q   <= prio_d;
         disp_q   <= disp_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state: arbitration, tenure countdown and winner loading.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      active_d = active_q;
      prio_d   = prio_q;
      disp_d   = disp_q;
      cnt_d    = cnt_q;
      do_load  = 1'b0;
      load_idx = win;

      unique case (state_q)
         IDLE: begin
            if (|req) do_load = 1'b1;
         end
         SHOW: begin
            if (req[active_q])
               disp_d = src_mux(active_q, src0_data, src1_data, src2_data);
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (req == 3'b000) begin
               state_d = IDLE;
               grant_d = 3'b000;
            end else if (win != active_q) begin
               do_load = 1'b1;
            end
`ifdef SEG_ARB_PREEMPT_EN
            // Score display jumps the queue whenever another source is shown.
            if (req[0] && active_q != 2'd0) begin
               do_load  = 1'b1;
               load_idx = 2'd0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         state_d  = SHOW;
         grant_d  = 3'b001 << load_idx;
         active_d = load_idx;
         cnt_d    = RELOAD;
         disp_d   = src_mux(load_idx, src0_data, src1_data, src2_data);
         prio_d   = (load_idx == 2'd2) ? 2'd0 : load_idx + 2'd1;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      grant      = grant_q;
      active_src = active_q;
      busy       = |grant_q;
      disp_data  = disp_q;
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4.
// Checks reset, single request, round-robin, sole holder, reset and preemption.
module tb_seg_display_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [15:0] src0_data, src1_data, src2_data;
   logic [2:0]  grant;
   logic [1:0]  active_src;
   logic        busy;
   logic [15:0] disp_data;

   int checks   = 0;
   int failures = 0;

   seg_display_arbiter #(
      .HOLD_CYCLES(4),
      .CNT_W(4),
      .IDLE_DATA(16'h0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .src0_data(src0_data),
      .src1_data(src1_data),
      .src2_data(src2_data),
      .grant(grant),
      .active_src(active_src),
      .busy(busy),
      .disp_data(disp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] exp_g;
   logic [1:0] exp_a;

   initial begin
      reset = 1'b0;
      req = 3'b000;
      src0_data = 16'h0000;
      src1_data = 16'h0000;
      src2_data = 16'h0000;

      // Reset and idle
      repeat (3) tick();
      check("rst_grant", grant, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_disp", disp_data, 16'h0000);
      check("rst_act", active_src, 2'd0);
      reset = 1'b1;
      tick();
      check("idle_grant", grant, 3'b000);
      check("idle_disp", disp_data, 16'h0000);

      // Single request
      src0_data = 16'h1234;
      req = 3'b001;
      tick();
      check("single_grant", grant, 3'b001);
      check("single_disp", disp_data, 16'h1234);
      check("single_busy", busy, 1'b1);
      src0_data = 16'h5678;
      tick();
      check("track_disp", disp_data, 16'h5678);
      req = 3'b000;
      src0_data = 16'h9999;
      tick();
      check("hold_n2", grant, 3'b001);
      tick();
      check("hold_n3", grant, 3'b001);
      tick();
      check("end_grant", grant, 3'b000);
      check("end_busy", busy, 1'b0);
      check("end_disp", disp_data, 16'h5678);
      check("end_act", active_src, 2'd0);

      // Round-robin with all requests held
      reset = 1'b0;
      tick();
      src0_data = 16'hA000;
      src1_data = 16'hB111;
      src2_data = 16'hC222;
      reset = 1'b1;
      req = 3'b111;
      for (int i = 0; i < 13; i++) begin
         tick();
         exp_a = 2'((i / 4) % 3);
         exp_g = 3'b001 << exp_a;
         check($sformatf("rr_grant%0d", i), grant, exp_g);
         check($sformatf("rr_act%0d", i), active_src, exp_a);
         check($sformatf("rr_busy%0d", i), busy, 1'b1);
      end
      check("rr_disp", disp_data, 16'hA000);

      // Early release of source 1
      reset = 1'b0;
      req = 3'b000;
      tick();
      reset = 1'b1;
      req = 3'b010;
      tick();
      check("er_grant0", grant, 3'b010);
      check("er_disp", disp_data, 16'hB111);
      req = 3'b000;
      for (int i = 1; i < 4; i++) begin
         tick();
         check($sformatf("er_grant%0d", i), grant, 3'b010);
      end
      tick();
      check("er_idle", grant, 3'b000);
      check("er_act", active_src, 2'd1);

      // Sole holder keeps the grant, then yields to source 2
      req = 3'b010;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("sole%0d", i), grant, 3'b010);
      end
      req = 3'b110;
      tick();
      check("sole_switch", grant, 3'b100);
      check("sole_act", active_src, 2'd2);
      check("sole_disp", disp_data, 16'hC222);

      // Reset mid-tenure (counter=2)
      tick();
      reset = 1'b0;
      tick();
      check("mrst_grant", grant, 3'b000);
      check("mrst_disp", disp_data, 16'h0000);
      check("mrst_act", active_src, 2'd0);
      check("mrst_busy", busy, 1'b0);
      reset = 1'b1;
      req = 3'b000;
      tick();

      // Score request while source 2 has just been granted
      req = 3'b100;
      tick();
      check("pre_g2", grant, 3'b100);
      req = 3'b101;
`ifdef SEG_ARB_PREEMPT_EN
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("pre_g0_%0d", i), grant, 3'b001);
      end
      check("pre_disp", disp_data, 16'hA000);
      tick();
      check("pre_back", grant, 3'b100);
`else
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("nopre_g2_%0d", i), grant, 3'b100);
      end
      tick();
      check("nopre_sw", grant, 3'b001);
      check("nopre_disp", disp_data, 16'hA000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
